// File: rtl/parking_pkg.sv
// ---------------------------------------------------------------------------
// parking_pkg
// Constants shared by the parking-gate traffic emulator and the gate decoder
// it drives.
//   - FSM state encodings (3 bits)
//   - direction codes for a car movement
//   - two-bit photo-sensor patterns, bit1 = outer sensor a, bit0 = inner b
//   - helpers that map an emulator state to its sensor pattern
// ---------------------------------------------------------------------------
package parking_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE  = 3'd0;
    localparam state_t ST_LEAD  = 3'd1;
    localparam state_t ST_BOTH  = 3'd2;
    localparam state_t ST_TRAIL = 3'd3;
    localparam state_t ST_CLEAR = 3'd4;

    localparam logic DIR_ENTER = 1'b0;
    localparam logic DIR_EXIT  = 1'b1;

    localparam logic [1:0] SNS_NONE = 2'b00;
    localparam logic [1:0] SNS_A    = 2'b10;
    localparam logic [1:0] SNS_B    = 2'b01;
    localparam logic [1:0] SNS_AB   = 2'b11;

    // A car entering breaks the outer beam first and leaves through the inner
    // one; an exiting car does the mirror image. IDLE and CLEAR are both dark.
    function automatic logic [1:0] sensorPattern(input state_t state, input logic dir);
        logic [1:0] pattern;
        pattern = SNS_NONE;
        case (state)
            ST_LEAD:  pattern = (dir == DIR_EXIT) ? SNS_B : SNS_A;
            ST_BOTH:  pattern = SNS_AB;
            ST_TRAIL: pattern = (dir == DIR_EXIT) ? SNS_A : SNS_B;
            default:  pattern = SNS_NONE;
        endcase
        return pattern;
    endfunction

    // The three timed states in which a car is physically under the sensors.
    function automatic logic isPhaseState(input state_t state);
        return (state == ST_LEAD) || (state == ST_BOTH) || (state == ST_TRAIL);
    endfunction

endpackage

// File: rtl/parking_gate_emulator_phase_timer.sv
// ---------------------------------------------------------------------------
// phase_timer
// Down-counter that measures how long one sensor phase is held.
// Ports:
//   clk       in  system clock, rising edge
//   reset_n   in  asynchronous active-low reset
//   load_i    in  reload the counter for a fresh phase (wins over tick_i)
//   tick_i    in  count one cycle of the current phase
//   expire_o  out high during the last cycle of the phase
// ---------------------------------------------------------------------------
module phase_timer #(
    parameter int PHASE_CYCLES = 16
) (
    input  logic clk,
    input  logic reset_n,
    input  logic load_i,
    input  logic tick_i,
    output logic expire_o
);

    // A one-cycle phase still needs a one-bit counter to hold the value zero.
    localparam int TW = (PHASE_CYCLES > 1) ? $clog2(PHASE_CYCLES) : 1;
    localparam logic [TW-1:0] RELOAD = TW'(PHASE_CYCLES - 1);

    logic [TW-1:0] count_q;
    logic [TW-1:0] count_d;

    // The counter is loaded with PHASE_CYCLES-1 on the edge that enters a
    // phase, so reaching zero marks the final cycle. It parks at zero rather
    // than wrapping, because outside a phase its value is never consulted.
    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = RELOAD;
        end else if (tick_i && (count_q != '0)) begin
            count_d = count_q - 1'b1;
        end
    end

    // Plain state register for the counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expire_o = (count_q == '0);

endmodule

// File: rtl/parking_gate_emulator.sv
// ---------------------------------------------------------------------------
// parking_gate_emulator
// Drives the two photo-sensor lines of a parking gate through the sequence
// of one car entering or leaving, per accepted command, and keeps a
// saturating count of cars in the lot.
// Ports:
//   clk        in   system clock, rising edge
//   reset_n    in   asynchronous active-low reset
//   start      in   request one car movement (taken only while ready)
//   dir        in   0 = enter, 1 = exit, sampled with start
//   abort      in   cancel the car currently under the sensors
//   a, b       out  registered outer / inner sensor lines
//   ready      out  a new start is accepted this cycle
//   done       out  one-cycle pulse when a movement completes
//   reject     out  one-cycle pulse when a start is refused
//   occupancy  out  cars currently in the lot
//   full       out  occupancy == CAPACITY
//   empty      out  occupancy == 0
// ---------------------------------------------------------------------------
module parking_gate_emulator
    import parking_pkg::*;
#(
    parameter  int PHASE_CYCLES = 16,
    parameter  int CAPACITY     = 8,
    localparam int CW           = $clog2(CAPACITY + 1)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          start,
    input  logic          dir,
    input  logic          abort,
    output logic          a,
    output logic          b,
    output logic          ready,
    output logic          done,
    output logic          reject,
    output logic [CW-1:0] occupancy,
    output logic          full,
    output logic          empty
);

    localparam logic [CW-1:0] CAP_VAL = CW'(CAPACITY);

    state_t        state_q;
    state_t        state_d;
    logic          dirLatch_q;
    logic          dirLatch_d;
    logic [CW-1:0] occupancy_q;
    logic [CW-1:0] occupancy_d;
    logic          a_q;
    logic          b_q;
    logic          done_q;
    logic          reject_q;
    logic [1:0]    sns_d;
    logic          done_d;
    logic          reject_d;

    logic          phaseExpire;
    logic          timerLoad;
    logic          timerTick;
    logic          startSeen;
    logic          startLegal;
    logic          accept;

    phase_timer #(
        .PHASE_CYCLES (PHASE_CYCLES)
    ) uPhaseTimer (
        .clk      (clk),
        .reset_n  (reset_n),
        .load_i   (timerLoad),
        .tick_i   (timerTick),
        .expire_o (phaseExpire)
    );

    assign ready = (state_q == ST_IDLE) || (state_q == ST_CLEAR);

    // The occupancy changes on the edge that leaves CLEAR, using the direction
    // latched for the car that just finished. The clamp guards against any
    // count outside 0..CAPACITY even though the legality check below should
    // already prevent it.
    always_comb begin
        occupancy_d = occupancy_q;
        if (state_q == ST_CLEAR) begin
            if (dirLatch_q == DIR_ENTER) begin
                if (occupancy_q != CAP_VAL) begin
                    occupancy_d = occupancy_q + 1'b1;
                end
            end else begin
                if (occupancy_q != '0) begin
                    occupancy_d = occupancy_q - 1'b1;
                end
            end
        end
    end

    // A start is judged against the count that will hold once the current
    // car (if any) is booked. In CLEAR that is the updated value, so a car
    // queued back-to-back can never push the lot past full or below empty.
    // abort outranks start: a start seen together with abort is silently
    // dropped and neither accepted nor rejected.
    always_comb begin
        startSeen  = start && ready && !abort;
        startLegal = (dir == DIR_ENTER) ? (occupancy_d != CAP_VAL) : (occupancy_d != '0);
        accept     = startSeen && startLegal;
    end

    // State register together with the direction latch and the lot count.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            dirLatch_q  <= DIR_ENTER;
            occupancy_q <= '0;
        end else begin
            state_q     <= state_d;
            dirLatch_q  <= dirLatch_d;
            occupancy_q <= occupancy_d;
        end
    end

    // Next-state logic. Each timed phase moves on when the phase timer
    // expires; abort during a timed phase drops straight back to IDLE without
    // booking the car. CLEAR lasts one cycle and either chains directly into
    // the next car or returns to IDLE.
    always_comb begin
        state_d    = state_q;
        dirLatch_d = dirLatch_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d    = ST_LEAD;
                    dirLatch_d = dir;
                end
            end
            ST_LEAD: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (phaseExpire) begin
                    state_d = ST_BOTH;
                end
            end
            ST_BOTH: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (phaseExpire) begin
                    state_d = ST_TRAIL;
                end
            end
            ST_TRAIL: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (phaseExpire) begin
                    state_d = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                if (accept) begin
                    state_d    = ST_LEAD;
                    dirLatch_d = dir;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output decode works from the upcoming state so that the registered a/b,
    // done and reject line up with the state register. The timer is reloaded
    // whenever a timed phase is entered and counts while one is active.
    always_comb begin
        sns_d     = sensorPattern(state_d, dirLatch_d);
        done_d    = (state_d == ST_CLEAR);
        reject_d  = startSeen && !startLegal;
        timerLoad = isPhaseState(state_d) && (state_d != state_q);
        timerTick = isPhaseState(state_q);
    end

    // Output registers; reset clears the sensor lines immediately.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            a_q      <= 1'b0;
            b_q      <= 1'b0;
            done_q   <= 1'b0;
            reject_q <= 1'b0;
        end else begin
            a_q      <= sns_d[1];
            b_q      <= sns_d[0];
            done_q   <= done_d;
            reject_q <= reject_d;
        end
    end

    assign a         = a_q;
    assign b         = b_q;
    assign done      = done_q;
    assign reject    = reject_q;
    assign occupancy = occupancy_q;
    assign full      = (occupancy_q == CAP_VAL);
    assign empty     = (occupancy_q == '0);

endmodule
